multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Moore FSM sequencing a multi-cycle MIPS datapath: fetch, decode, execute, memory, writeback.
//  Decodes the same ISA subset as the single-cycle decoder: R-type, jr, lw, sw, addi, beq, bne, j, jal.
//  Drives the PC, IR, memory, register file and ALU mux/enable controls.
//  opcode/funct come from the IR. They are stable from DECODE until the next FETCH completes.
// PARAMETERS
//  STATE_W      4    state register width (states 0..13)
//  MEM_TIMEOUT  255  max wait cycles per memory access (used only with MEM_WAIT_EN)
// PORTS
//  clk          in   1  rising-edge clock
//  rst_n        in   1  asynchronous, active-low reset
//  opcode       in   6  IR[31:26]
//  funct        in   6  IR[5:0]
//  alu_zero     in   1  ALU zero flag
//  mem_ready    in   1  memory access complete (MEM_WAIT_EN only)
//  pc_write     out  1  PC load enable, already qualified for branches
//  ir_write     out  1  IR load enable
//  i_or_d       out  1  mem address: 0=PC, 1=ALUOut
//  mem_read     out  1  memory read strobe
//  mem_write    out  1  memory write strobe
//  reg_write    out  1  register file write enable
//  reg_dest     out  2  write reg: 0=rt, 1=rd, 2=$31
//  mem_to_reg   out  2  write data: 0=ALUOut, 1=MDR, 2=PC
//  alu_src_a    out  1  0=PC, 1=A reg
//  alu_src_b    out  2  0=B reg, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
//  alu_op       out  2  0=add, 1=sub, 2=use funct
//  pc_source    out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target, 3=A reg (jr)
//  illegal_op   out  1  1-cycle pulse in DECODE for an unsupported opcode
//  bus_err      out  1  1-cycle pulse on memory timeout (0 without MEM_WAIT_EN)
//  state        out  STATE_W  current state, for debug
// BEHAVIOUR
//  States: RST=0 FETCH=1 DECODE=2 MADDR=3 MRD=4 MWB=5 MWR=6 REXE=7 RWB=8 IEXE=9 IWB=10 BR=11 JMP=12 JR=13.
//  Reset: state=RST, wait counter=0. In RST every output is 0 except state. RST -> FETCH unconditionally.
//  Any output not listed for a state is 0.
//  FETCH: mem_read, ir_write, pc_write; src_a=0, src_b=1, alu_op=0, pc_src=0. -> DECODE.
//  DECODE: src_a=0, src_b=3, alu_op=0 (precompute branch target). Next state by opcode:
//    0x00 with funct=0x08 -> JR; other 0x00 -> REXE; 0x23/0x2B -> MADDR; 0x08 -> IEXE.
//    0x04/0x05 -> BR; 0x02/0x03 -> JMP.
//    Any other opcode: illegal_op=1 -> FETCH. No register or memory writes occur.
//  MADDR: src_a=1, src_b=2, alu_op=0. -> MRD for lw, MWR for sw.
//  MRD: mem_read, i_or_d=1. -> MWB.
//  MWB: reg_write, reg_dest=0, mem_to_reg=1. -> FETCH.
//  MWR: mem_write, i_or_d=1. -> FETCH.
//  REXE: src_a=1, src_b=0, alu_op=2. -> RWB.
//  RWB: reg_write, reg_dest=1, mem_to_reg=0. -> FETCH.
//  IEXE: src_a=1, src_b=2, alu_op=0. -> IWB.
//  IWB: reg_write, reg_dest=0, mem_to_reg=0. -> FETCH.
//  BR: src_a=1, src_b=0, alu_op=1, pc_src=1.
//    pc_write = beq ? alu_zero : ~alu_zero (combinational from alu_zero). -> FETCH.
//  JMP: pc_write, pc_src=2. For jal also reg_write, reg_dest=2, mem_to_reg=2 (PC already holds PC+4). -> FETCH.
//  JR: pc_write, pc_src=3. -> FETCH.
//  Latency in cycles, FETCH through last state: R/addi/sw 4, lw 5, beq/bne/j/jal/jr 3.
//  Outputs are combinational decodes of state. Only pc_write in BR also depends on alu_zero.
//  rst_n low in any state: immediate return to RST with outputs 0. An in-flight access is abandoned without writeback.
// CONFIGURATION
//  MEM_WAIT_EN defined:
//    FETCH, MRD and MWR hold until mem_ready=1.
//    In FETCH, ir_write and pc_write assert only in the cycle where mem_ready=1.
//    mem_read/mem_write stay high while waiting.
//    An 8-bit wait counter clears on entering a memory state and increments each cycle with mem_ready=0.
//    Counter == MEM_TIMEOUT with mem_ready=0: bus_err pulses 1 cycle.
//      On that cycle: no ir_write, pc_write or reg_write; state -> FETCH; counter clears.
//    mem_ready=1 in the timeout cycle wins: normal completion, bus_err=0.
//  MEM_WAIT_EN undefined: every memory state takes 1 cycle. mem_ready is ignored. bus_err=0. No counter is built.
// TESTING
//  1 Reset: rst_n=0 for 3 cycles, then release.
//    -> state=0 with all outputs 0; next cycle FETCH with mem_read=ir_write=pc_write=1.
//  2 lw (opcode 0x23) -> states 1,2,3,4,5,1.
//    In MWB: reg_write=1, reg_dest=0, mem_to_reg=1. Repeat with R-type funct 0x20 -> 1,2,7,8,1, reg_dest=1.
//  3 beq (0x04) with alu_zero=1 -> pc_write=1, pc_src=1 in BR.
//    With alu_zero=0 -> pc_write=0. bne (0x05) gives the inverted results.
//  4 jal (0x03) -> JMP: pc_write=1, pc_src=2, reg_write=1, reg_dest=2, mem_to_reg=2.
//    jr (opcode 0, funct 0x08) -> JR, pc_src=3, reg_write=0.
//  5 opcode 0x3F -> illegal_op=1 for exactly 1 cycle in DECODE, no write strobes, then FETCH.
//    rst_n dropped in MRD -> state=0 asynchronously.
//  6 MEM_WAIT_EN with MEM_TIMEOUT=4:
//    lw with mem_ready low for 2 cycles in MRD -> holds MRD 3 cycles, then MWB.
//    mem_ready held low -> bus_err after 4 wait cycles, no reg_write, then FETCH.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] reg_dest;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic       bus_err;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
           reg_dest, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
           illegal_op, bus_err
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
           reg_dest, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
           illegal_op, bus_err
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a multi-cycle MIPS datapath (R-type, jr, lw, sw, addi, beq, bne, j, jal).
// Define MEM_WAIT_EN to make memory states wait on mem_ready with a timeout (bus_err).
module multicycle_control #(
  parameter int unsigned STATE_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.master  bus,
  output logic [STATE_W-1:0]    state
);

  if (STATE_W < 4 || MEM_TIMEOUT > 255) begin : g_bad_cfg
    $error("multicycle_control: STATE_W must be >= 4 and MEM_TIMEOUT <= 255");
  end

  typedef enum logic [STATE_W-1:0] {
    S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_MADDR = 3, S_MRD = 4, S_MWB = 5, S_MWR = 6,
    S_REXE = 7, S_RWB = 8, S_IEXE = 9, S_IWB = 10, S_BR = 11, S_JMP = 12, S_JR = 13
  } state_t;

  state_t state_q, state_d;
  logic   dec_illegal;
  logic   mem_ok;
  logic   timeout;

`ifdef MEM_WAIT_EN
  logic [7:0] wait_cnt;
  logic       in_mem;

  assign in_mem  = (state_q == S_FETCH) || (state_q == S_MRD) || (state_q == S_MWR);
  assign mem_ok  = bus.mem_ready;
  // mem_ready in the timeout cycle takes priority: that is a normal completion.
  assign timeout = in_mem && !bus.mem_ready && (wait_cnt == 8'(MEM_TIMEOUT));

  // Timeout from FETCH re-enters FETCH without a state change, so clear explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= '0;
    else if ((state_d != state_q) || timeout)
      wait_cnt <= '0;
    else if (in_mem && !bus.mem_ready)
      wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign mem_ok  = 1'b1;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    dec_illegal = 1'b0;
    unique case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (mem_ok) state_d = S_DECODE;
                else if (timeout) state_d = S_FETCH;
      S_DECODE: begin
        unique case (bus.opcode)
          6'h00:        state_d = (bus.funct == 6'h08) ? S_JR : S_REXE;
          6'h23, 6'h2B: state_d = S_MADDR;
          6'h08:        state_d = S_IEXE;
          6'h04, 6'h05: state_d = S_BR;
          6'h02, 6'h03: state_d = S_JMP;
          default: begin
            state_d     = S_FETCH;
            dec_illegal = 1'b1;
          end
        endcase
      end
      S_MADDR:  state_d = (bus.opcode == 6'h2B) ? S_MWR : S_MRD;
      S_MRD:    if (mem_ok) state_d = S_MWB;
                else if (timeout) state_d = S_FETCH;
      S_MWR:    if (mem_ok || timeout) state_d = S_FETCH;
      S_REXE:   state_d = S_RWB;
      S_IEXE:   state_d = S_IWB;
      S_MWB, S_RWB, S_IWB, S_BR, S_JMP, S_JR: state_d = S_FETCH;
      default:  state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dest   = '0;
    bus.mem_to_reg = '0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = '0;
    bus.alu_op     = '0;
    bus.pc_source  = '0;
    bus.illegal_op = 1'b0;
    bus.bus_err    = timeout;
    unique case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.ir_write  = mem_ok;
        bus.pc_write  = mem_ok;
        bus.alu_src_b = 2'd1;
      end
      S_DECODE: begin
        bus.alu_src_b  = 2'd3;
        bus.illegal_op = dec_illegal;
      end
      S_MADDR, S_IEXE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd2;
      end
      S_MRD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'd1;
      end
      S_MWR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      S_REXE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'd2;
      end
      S_RWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dest  = 2'd1;
      end
      S_IWB: bus.reg_write = 1'b1;
      S_BR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'd1;
        bus.pc_source = 2'd1;
        bus.pc_write  = (bus.opcode == 6'h04) ? bus.alu_zero : !bus.alu_zero;
      end
      S_JMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'd2;
        if (bus.opcode == 6'h03) begin
          bus.reg_write  = 1'b1;
          bus.reg_dest   = 2'd2;
          bus.mem_to_reg = 2'd2;
        end
      end
      S_JR: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'd3;
      end
      default: ;
    endcase
  end

endmodule
